controller_uart_rx_bridge: RTL and testbench

Receiving end of the joystick-controller UART link. Deserialises 8N1 bytes from the controller's TX line and frames them into fixed-length packets: sync byte, stick value, button byte and optional checksum. Commits each valid packet atomically into two registers, which are exposed through a zero-latency Avalon-MM read-only slave. The FPGA top level polls this slave: address 0 returns the stick value, address 1 returns the button state.

---
 rtl/controller_uart_rx_bridge.sv | 212 +++++++++++++++++++++
 tb/tb_controller_uart_rx_bridge.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/controller_uart_rx_bridge.sv
// rtl/controller_uart_rx_bridge.sv - UART 8N1 receiver, packet parser and Avalon-MM read-only register slave
// Optional checksum byte enabled by defining CONTROLLER_RX_CHECKSUM_EN.
module controller_uart_rx_bridge #(
    parameter int          CLK_HZ       = 50000000,
    parameter int          BAUD         = 115200,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    input  logic       avs_chipselect,
    input  logic       avs_read,
    input  logic       avs_address,
    output logic [7:0] avs_readdata,
    output logic       pkt_stb,
    output logic       err_stb
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TO_LIMIT     = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
    localparam int TO_W         = $clog2(TO_LIMIT + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
`ifdef CONTROLLER_RX_CHECKSUM_EN
    typedef enum logic [1:0] {P_HUNT, P_VAL, P_BTN, P_CHK} p_state_t;
`else
    typedef enum logic [1:0] {P_HUNT, P_VAL, P_BTN} p_state_t;
`endif

    logic             rx_meta_q, rx_s_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             brk_q;
    logic             rx_tick, byte_valid, rx_frame_err;

    p_state_t         p_state_q, p_state_d;
    logic [7:0]       val_stage_q;
    logic [7:0]       value_q;
    logic             button_q;
    logic [TO_W-1:0]  to_cnt_q;
    logic             p_timeout, p_commit, p_chk_err, commit_btn;
`ifdef CONTROLLER_RX_CHECKSUM_EN
    logic [7:0]       btn_byte_q;
`endif

    // Two-flop synchroniser; idles high so reset does not look like a start bit
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rxd;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Sample point: half a bit after the start edge, then every full bit period
    always_comb begin
        rx_tick = 1'b0;
        if (rx_state_q == RX_START)
            rx_tick = (clk_cnt_q == CNT_W'(HALF_BIT - 1));
        else
            rx_tick = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    end

    // RX state register
    always_ff @(posedge clk) begin
        if (reset) rx_state_q <= RX_IDLE;
        else       rx_state_q <= rx_state_d;
    end

    // RX next state; after a bad stop bit, STOP holds until the line returns high
    always_comb begin
        rx_state_d = rx_state_q;
        case (rx_state_q)
            RX_IDLE:  if (!rx_s_q) rx_state_d = RX_START;
            RX_START: if (rx_tick) rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_tick && bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
            RX_STOP: begin
                if (brk_q) begin
                    if (rx_s_q) rx_state_d = RX_IDLE;
                end else if (rx_tick && rx_s_q) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default:  rx_state_d = RX_IDLE;
        endcase
    end

    // RX outputs: completed byte or framing error at the mid-stop-bit sample
    always_comb begin
        byte_valid   = (rx_state_q == RX_STOP) && !brk_q && rx_tick && rx_s_q;
        rx_frame_err = (rx_state_q == RX_STOP) && !brk_q && rx_tick && !rx_s_q;
    end

    // RX datapath: bit-period counter, bit counter, LSB-first shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            brk_q     <= 1'b0;
        end else begin
            case (rx_state_q)
                RX_IDLE: begin
                    clk_cnt_q <= '0;
                    bit_cnt_q <= '0;
                    brk_q     <= 1'b0;
                end
                RX_START: clk_cnt_q <= rx_tick ? '0 : clk_cnt_q + 1'b1;
                RX_DATA: begin
                    clk_cnt_q <= rx_tick ? '0 : clk_cnt_q + 1'b1;
                    if (rx_tick) begin
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                end
                RX_STOP: begin
                    clk_cnt_q <= rx_tick ? '0 : clk_cnt_q + 1'b1;
                    if (rx_frame_err) brk_q <= 1'b1;
                end
                default: clk_cnt_q <= '0;
            endcase
        end
    end

    // Inter-byte timeout fires only between bytes of a partially received packet
    always_comb begin
        p_timeout = (p_state_q != P_HUNT) && !byte_valid &&
                    (to_cnt_q == TO_W'(TO_LIMIT - 1));
    end

    // Parser state register
    always_ff @(posedge clk) begin
        if (reset) p_state_q <= P_HUNT;
        else       p_state_q <= p_state_d;
    end

    // Parser next state; sync byte only counts as a marker while hunting
    always_comb begin
        p_state_d = p_state_q;
        if (rx_frame_err || p_timeout) begin
            p_state_d = P_HUNT;
        end else if (byte_valid) begin
            case (p_state_q)
                P_HUNT: if (shift_q == SYNC_BYTE) p_state_d = P_VAL;
                P_VAL:  p_state_d = P_BTN;
`ifdef CONTROLLER_RX_CHECKSUM_EN
                P_BTN:  p_state_d = P_CHK;
                P_CHK:  p_state_d = P_HUNT;
`else
                P_BTN:  p_state_d = P_HUNT;
`endif
                default: p_state_d = P_HUNT;
            endcase
        end
    end

    // Parser outputs: commit on the last byte of a good packet
    always_comb begin
`ifdef CONTROLLER_RX_CHECKSUM_EN
        p_commit   = byte_valid && (p_state_q == P_CHK) &&
                     (shift_q == (val_stage_q ^ btn_byte_q));
        p_chk_err  = byte_valid && (p_state_q == P_CHK) &&
                     (shift_q != (val_stage_q ^ btn_byte_q));
        commit_btn = btn_byte_q[0];
`else
        p_commit   = byte_valid && (p_state_q == P_BTN);
        p_chk_err  = 1'b0;
        commit_btn = shift_q[0];
`endif
        pkt_stb = p_commit && !reset;
        err_stb = (rx_frame_err || p_timeout || p_chk_err) && !reset;
    end

    // Parser datapath: staging bytes, atomic register commit, timeout counter
    always_ff @(posedge clk) begin
        if (reset) begin
            val_stage_q <= '0;
            value_q     <= '0;
            button_q    <= 1'b0;
            to_cnt_q    <= '0;
`ifdef CONTROLLER_RX_CHECKSUM_EN
            btn_byte_q  <= '0;
`endif
        end else begin
            if (byte_valid && p_state_q == P_VAL) val_stage_q <= shift_q;
`ifdef CONTROLLER_RX_CHECKSUM_EN
            if (byte_valid && p_state_q == P_BTN) btn_byte_q <= shift_q;
`endif
            if (p_commit) begin
                value_q  <= val_stage_q;
                button_q <= commit_btn;
            end
            if (p_state_q == P_HUNT || byte_valid) to_cnt_q <= '0;
            else                                   to_cnt_q <= to_cnt_q + 1'b1;
        end
    end

    // Zero-latency read mux, driven low when not being read
    always_comb begin
        avs_readdata = 8'h00;
        if (avs_chipselect && avs_read)
            avs_readdata = avs_address ? {7'b0, button_q} : value_q;
    end

endmodule

// File: tb/tb_controller_uart_rx_bridge.sv
// tb/tb_controller_uart_rx_bridge.sv - directed self-checking bench for controller_uart_rx_bridge
module tb_controller_uart_rx_bridge;

    localparam int         CPB  = 50000000 / 115200;
    localparam logic [7:0] SYNC = 8'hA5;
    // Start-bit drive to byte_valid: 2 sync flops + half bit + 8 data bits + stop bit
    localparam int         BV_LAT = 2 + CPB / 2 + 9 * CPB;
    localparam int         TO_EXP = BV_LAT + 20 * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rxd = 1'b1;
    logic       cs = 1'b0;
    logic       rd = 1'b0;
    logic       addr = 1'b0;
    logic [7:0] rdata;
    logic       pkt_stb, err_stb;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pkt_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    int last_err_cyc = -1;
    int start_cyc = 0;
    logic [7:0] rd_at_commit = 8'hFF;
    logic [7:0] rd_after_commit = 8'hFF;
    logic       grab_next = 1'b0;

    controller_uart_rx_bridge #(
        .CLK_HZ(50000000), .BAUD(115200), .SYNC_BYTE(8'hA5), .TIMEOUT_BITS(20)
    ) dut (
        .clk(clk), .reset(reset), .rxd(rxd),
        .avs_chipselect(cs), .avs_read(rd), .avs_address(addr),
        .avs_readdata(rdata), .pkt_stb(pkt_stb), .err_stb(err_stb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (grab_next) begin
            rd_after_commit <= rdata;
            grab_next <= 1'b0;
        end
        if (pkt_stb) begin
            pkt_cnt <= pkt_cnt + 1;
            if (pkt_cnt == 0) begin
                rd_at_commit <= rdata;
                grab_next <= 1'b1;
            end
        end
        if (err_stb) begin
            err_cnt <= err_cnt + 1;
            last_err_cyc <= cyc;
        end
        if (pkt_stb && err_stb) both_cnt <= both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        start_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
    endtask

    task automatic send_pkt(input logic [7:0] v, input logic [7:0] b);
        send_byte(SYNC, 1'b1);
        send_byte(v, 1'b1);
        send_byte(b, 1'b1);
`ifdef CONTROLLER_RX_CHECKSUM_EN
        send_byte(v ^ b, 1'b1);
`endif
    endtask

    task automatic rd_reg(input logic a, output logic [7:0] d);
        cs = 1'b1;
        rd = 1'b1;
        addr = a;
        #1 d = rdata;
        @(negedge clk);
        cs = 1'b0;
        rd = 1'b0;
    endtask

    logic [7:0] d;
    int p0, e0, t55;

    initial begin
        // Reset and idle reads
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        cs = 1'b1;
        rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr = i[0];
            #1 check(i[0] ? "rst_rd_btn" : "rst_rd_val", {24'b0, rdata}, 32'h0);
            @(negedge clk);
        end
        check("rst_pkt", pkt_cnt, 0);
        check("rst_err", err_cnt, 0);

        // First packet with reads held on address 0 across the commit
        addr = 1'b0;
        p0 = pkt_cnt; e0 = err_cnt;
        send_pkt(8'h3C, 8'h01);
        repeat (10) @(negedge clk);
        check("pkt1_stb", pkt_cnt - p0, 1);
        check("pkt1_err", err_cnt - e0, 0);
        check("pkt1_rd_commit_old", {24'b0, rd_at_commit}, 32'h00);
        check("pkt1_rd_next_new", {24'b0, rd_after_commit}, 32'h3C);
        rd = 1'b0;
        #1 check("no_read_zero", {24'b0, rdata}, 32'h0);
        cs = 1'b0;
        rd_reg(1'b0, d); check("pkt1_val", {24'b0, d}, 32'h3C);
        rd_reg(1'b1, d); check("pkt1_btn", {24'b0, d}, 32'h01);

`ifdef CONTROLLER_RX_CHECKSUM_EN
        // Bad checksum keeps old registers; following good packet commits
        p0 = pkt_cnt; e0 = err_cnt;
        send_byte(SYNC, 1'b1); send_byte(8'h3C, 1'b1);
        send_byte(8'h01, 1'b1); send_byte(8'h00, 1'b1);
        check("chk_bad_err", err_cnt - e0, 1);
        check("chk_bad_pkt", pkt_cnt - p0, 0);
        rd_reg(1'b0, d); check("chk_bad_val", {24'b0, d}, 32'h3C);
        send_pkt(8'h7F, 8'h00);
        rd_reg(1'b0, d); check("chk_good_val", {24'b0, d}, 32'h7F);
        rd_reg(1'b1, d); check("chk_good_btn", {24'b0, d}, 32'h00);
`endif

        // Framing error on the value byte
        p0 = pkt_cnt; e0 = err_cnt;
        send_byte(SYNC, 1'b1);
        send_byte(8'h20, 1'b0);
        send_bit(1'b1);
        check("frm_err", err_cnt - e0, 1);
        check("frm_pkt", pkt_cnt - p0, 0);

        // Garbage is ignored silently; next packet carries sync value as data and btn bit0 only
        e0 = err_cnt; p0 = pkt_cnt;
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("garbage_err", err_cnt - e0, 0);
        send_pkt(8'hA5, 8'hFE);
        check("garbage_pkt", pkt_cnt - p0, 1);
        check("garbage_err2", err_cnt - e0, 0);
        rd_reg(1'b0, d); check("sync_as_val", {24'b0, d}, 32'hA5);
        rd_reg(1'b1, d); check("btn_bit0", {24'b0, d}, 32'h00);

        // Short low glitch on idle line
        p0 = pkt_cnt; e0 = err_cnt;
        rxd = 1'b0;
        repeat (200) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        check("glitch_pkt", pkt_cnt - p0, 0);
        check("glitch_err", err_cnt - e0, 0);

        // Inter-byte timeout
        p0 = pkt_cnt; e0 = err_cnt;
        send_byte(SYNC, 1'b1);
        send_byte(8'h55, 1'b1);
        t55 = start_cyc;
        repeat (21 * CPB) @(negedge clk);
        check("to_err", err_cnt - e0, 1);
        check("to_cycle", last_err_cyc - t55, TO_EXP);
        check("to_pkt", pkt_cnt - p0, 0);
        send_pkt(8'h10, 8'h00);
        check("to_recover_pkt", pkt_cnt - p0, 1);
        rd_reg(1'b0, d); check("to_recover_val", {24'b0, d}, 32'h10);
        rd_reg(1'b1, d); check("to_recover_btn", {24'b0, d}, 32'h00);

        // Reset in the middle of a packet
        p0 = pkt_cnt; e0 = err_cnt;
        send_byte(SYNC, 1'b1);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        reset = 1'b1;
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        check("rst_mid_pkt", pkt_cnt - p0, 0);
        check("rst_mid_err", err_cnt - e0, 0);
        rd_reg(1'b0, d); check("rst_mid_val", {24'b0, d}, 32'h00);
        rd_reg(1'b1, d); check("rst_mid_btn", {24'b0, d}, 32'h00);
        check("never_both", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
